// File: rtl/alu_seq_core_if.sv
// Nibble-serial bus between the tile pins and the ALU sequencer core.
// The master drives strobe and data; the slave returns result nibble, flags and state.
interface alu_seq_core_if;
    logic       ctl;
    logic [3:0] din;
    logic [3:0] dout;
    logic       cout;
    logic       zero;
    logic       busy;
    logic [2:0] state;

    modport master (
        output ctl,
        output din,
        input  dout,
        input  cout,
        input  zero,
        input  busy,
        input  state
    );

    modport slave (
        input  ctl,
        input  din,
        output dout,
        output cout,
        output zero,
        output busy,
        output state
    );
endinterface

// File: rtl/alu_seq_core.sv
// Nibble-serial ALU sequencer: loads A, B and an opcode one nibble per strobe,
// executes in one cycle, then returns the WIDTH-bit result one nibble per strobe.
module alu_seq_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_core_if.slave  bus
);

    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int unsigned SW   = CW + 2;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [3:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;
    logic              acc_hold_q, acc_hold_d;

    logic              last_nib;
    logic [SW-1:0]     nib_lsb;
    logic [WIDTH-1:0]  nib_mask;
    logic [WIDTH-1:0]  nib_data;

    logic              cin;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  res;
    logic              res_c;

    // Nibble position helpers shared by load and show paths
    assign last_nib = (cnt_q == CW'(NNIB - 1));
    assign nib_lsb  = {cnt_q, 2'b00};
    assign nib_mask = WIDTH'(4'hF) << nib_lsb;
    assign nib_data = WIDTH'(bus.din) << nib_lsb;

    // Datapath: SUB is A + ~B + cin, so cin defaults to 1 for SUB unless chained
    always_comb begin
        cin   = op_q[2] ? cout_q : (op_q[1:0] == 2'b01);
        b_eff = op_q[0] ? ~b_q : b_q;
        sum   = {1'b0, a_q} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        case (op_q[1:0])
            2'b10: begin
                res   = a_q & b_q;
                res_c = 1'b0;
            end
            2'b11: begin
                res   = a_q ^ b_q;
                res_c = 1'b0;
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_A;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            acc_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            acc_hold_q <= acc_hold_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        acc_hold_d = acc_hold_q;

        case (state_q)
            LOAD_A: begin
                if (bus.ctl) begin
                    a_d = (a_q & ~nib_mask) | nib_data;
                    if (last_nib) begin
                        state_d = LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (bus.ctl) begin
                    b_d = (b_q & ~nib_mask) | nib_data;
                    if (last_nib) begin
                        state_d = LOAD_OP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_OP: begin
                if (bus.ctl) begin
                    op_d    = bus.din;
                    state_d = EXEC;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                r_d     = res;
                cout_d  = res_c;
                zero_d  = (res == '0);
                cnt_d   = '0;
                state_d = SHOW;
            end
            SHOW: begin
                if (bus.ctl) begin
                    if (last_nib) begin
                        cnt_d = '0;
                        // Accumulate feeds the result back as A and skips the A load
                        if (op_q[3]) begin
                            a_d        = r_q;
                            acc_hold_d = 1'b1;
                            state_d    = LOAD_B;
                        end else begin
                            acc_hold_d = 1'b0;
                            state_d    = LOAD_A;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = LOAD_A;
                cnt_d      = '0;
                acc_hold_d = 1'b0;
            end
        endcase
    end

    assign bus.dout  = (state_q == SHOW) ? 4'(r_q >> nib_lsb) : 4'h0;
    assign bus.cout  = cout_q;
    assign bus.zero  = zero_q;
    assign bus.busy  = (state_q == EXEC);
    assign bus.state = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: vector table at WIDTH=8 with a result
// scoreboard, plus hand sequences for stall/reset and WIDTH=16 / WIDTH=4 builds.
module tb_alu_seq_core;

    localparam int unsigned W    = 8;
    localparam int unsigned NNIB = W / 4;
    localparam int          NV   = 11;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_seq_core_if bus8 ();
    alu_seq_core_if bus16 ();
    alu_seq_core_if bus4 ();

    alu_seq_core #(.WIDTH(8))  dut   (.clk(clk), .reset(reset), .bus(bus8.slave));
    alu_seq_core #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    alu_seq_core #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

    typedef struct {
        logic         load_a;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic [2:0]   end_state;
    } vec_t;

    vec_t       vecs [NV];
    logic [3:0] exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One strobe on the 8-bit DUT; called and returns on a falling edge
    task automatic strobe(input logic [3:0] nib);
        bus8.ctl = 1'b1;
        bus8.din = nib;
        @(negedge clk);
        bus8.ctl = 1'b0;
        bus8.din = 4'($urandom_range(0, 15));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] e;
        int         n;
        if (v.load_a) begin
            for (int k = 0; k < int'(NNIB); k++) strobe(v.a[4*k +: 4]);
            check($sformatf("v%0d state after A", idx), 32'(bus8.state), 32'd1);
        end
        for (int k = 0; k < int'(NNIB); k++) strobe(v.b[4*k +: 4]);
        check($sformatf("v%0d state after B", idx), 32'(bus8.state), 32'd2);
        strobe(v.op);
        for (int k = 0; k < int'(NNIB); k++) exp_q.push_back(v.r[4*k +: 4]);
        check($sformatf("v%0d exec state", idx), 32'(bus8.state), 32'd3);
        check($sformatf("v%0d busy", idx), 32'(bus8.busy), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d show state", idx), 32'(bus8.state), 32'd4);
        check($sformatf("v%0d cout", idx), 32'(bus8.cout), 32'(v.c));
        check($sformatf("v%0d zero", idx), 32'(bus8.zero), 32'(v.z));
        n = 0;
        while (exp_q.size() > 0 && n < int'(NNIB) + 2) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d dout nib%0d", idx, n), 32'(bus8.dout), 32'(e));
            strobe(4'h0);
            n++;
        end
        check($sformatf("v%0d end state", idx), 32'(bus8.state), 32'(v.end_state));
        check($sformatf("v%0d dout idle", idx), 32'(bus8.dout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                load  a      b      op    r      c     z     end
        vecs[0]  = '{1'b1, 8'h3C, 8'h25, 4'h0, 8'h61, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 8'h25, 8'h3C, 4'h1, 8'hE9, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 8'h40, 8'h40, 4'h1, 8'h00, 1'b1, 1'b1, 3'd0};
        vecs[3]  = '{1'b1, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1, 3'd0};
        vecs[4]  = '{1'b1, 8'h00, 8'h00, 4'h4, 8'h01, 1'b0, 1'b0, 3'd0};
        vecs[5]  = '{1'b1, 8'hF0, 8'h3C, 4'h2, 8'h30, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{1'b1, 8'hA5, 8'hA5, 4'h3, 8'h00, 1'b0, 1'b1, 3'd0};
        vecs[7]  = '{1'b1, 8'h10, 8'h01, 4'h5, 8'h0E, 1'b1, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, 8'h10, 8'h05, 4'h8, 8'h15, 1'b0, 1'b0, 3'd1};
        vecs[9]  = '{1'b0, 8'h00, 8'h05, 4'h8, 8'h1A, 1'b0, 1'b0, 3'd1};
        vecs[10] = '{1'b0, 8'h00, 8'hF0, 4'h8, 8'h0A, 1'b1, 1'b0, 3'd1};

        bus8.ctl  = 1'b0; bus8.din  = 4'h0;
        bus16.ctl = 1'b0; bus16.din = 4'h0;
        bus4.ctl  = 1'b0; bus4.din  = 4'h0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset state",  32'(bus8.state), 32'd0);
        check("reset dout",   32'(bus8.dout),  32'd0);
        check("reset cout",   32'(bus8.cout),  32'd0);
        check("reset zero",   32'(bus8.zero),  32'd0);
        check("reset busy",   32'(bus8.busy),  32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Stall mid-B-load: nothing may move while ctl is low
        strobe(4'h3);
        repeat (10) begin
            bus8.din = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        check("stall state", 32'(bus8.state), 32'd1);
        check("stall dout",  32'(bus8.dout),  32'd0);
        check("stall cout",  32'(bus8.cout),  32'd1);

        // Reset with ctl high must still win
        reset    = 1'b1;
        bus8.ctl = 1'b1;
        bus8.din = 4'hF;
        @(negedge clk);
        reset    = 1'b0;
        bus8.ctl = 1'b0;
        check("mid reset state", 32'(bus8.state), 32'd0);
        check("mid reset dout",  32'(bus8.dout),  32'd0);
        check("mid reset cout",  32'(bus8.cout),  32'd0);
        check("mid reset zero",  32'(bus8.zero),  32'd0);
        run_vec(vecs[0], 100);

        // WIDTH=16: 0xFFFF + 0x0001
        begin
            logic [3:0] seq16 [9];
            seq16 = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
            for (int k = 0; k < 9; k++) begin
                bus16.ctl = 1'b1;
                bus16.din = seq16[k];
                @(negedge clk);
            end
            bus16.ctl = 1'b0;
            check("w16 busy", 32'(bus16.busy), 32'd1);
            @(negedge clk);
            check("w16 cout", 32'(bus16.cout), 32'd1);
            check("w16 zero", 32'(bus16.zero), 32'd1);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("w16 dout nib%0d", k), 32'(bus16.dout), 32'd0);
                check($sformatf("w16 show state %0d", k), 32'(bus16.state), 32'd4);
                bus16.ctl = 1'b1;
                @(negedge clk);
                bus16.ctl = 1'b0;
            end
            check("w16 end state", 32'(bus16.state), 32'd0);
        end

        // WIDTH=4: 0x9 + 0x8
        begin
            logic [3:0] seq4 [3];
            seq4 = '{4'h9, 4'h8, 4'h0};
            for (int k = 0; k < 3; k++) begin
                bus4.ctl = 1'b1;
                bus4.din = seq4[k];
                @(negedge clk);
            end
            bus4.ctl = 1'b0;
            check("w4 busy", 32'(bus4.busy), 32'd1);
            @(negedge clk);
            check("w4 dout", 32'(bus4.dout), 32'd1);
            check("w4 cout", 32'(bus4.cout), 32'd1);
            check("w4 zero", 32'(bus4.zero), 32'd0);
            bus4.ctl = 1'b1;
            @(negedge clk);
            bus4.ctl = 1'b0;
            check("w4 end state", 32'(bus4.state), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
